prog_loader: RTL and testbench

Serial program loader for the RAT computer: consumes a byte stream from the UART receiver, assembles 18-bit instructions and writes them into the writable program memory that feeds the CPU's instruction register. While a frame is in progress it holds the CPU in reset, then releases it with DONE or ERR status. It replaces rebuilding the bitstream for every new `.mem` image.

---
 rtl/prog_loader_pkg.sv | 6 +
 rtl/loader_timeout.sv | 21 ++
 rtl/prog_loader.sv | 131 +++++++++++++
 tb/tb_prog_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared states and constants for the serial program loader
package prog_loader_pkg;
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, B0, B1, B2, WRITE, CHK} state_t;
    localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
    localparam logic [15:0] MAX_WORDS     = 16'd1024;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte idle watchdog; down-counter reloaded by i_clr, expires at zero while enabled
module loader_timeout #(
    parameter int TIMEOUT = 50_000_000
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    logic [W-1:0] r_cnt;
    // reload on clear, otherwise count idle cycles down to zero and hold there
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= LOAD;
        else if (i_clr) r_cnt <= LOAD;
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == '0);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: assembles 18-bit words from a byte stream and writes program memory; optional XOR check byte via PROG_LOADER_CHKSUM_EN
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 18,
    parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int          TIMEOUT   = 50_000_000
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_hold,
    output logic              o_done,
    output logic              o_err
);
    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_word;
    logic              r_rx_ready, r_we, r_hold, r_done, r_err;
    logic              w_accept, w_expire, w_abort, w_finish, w_chk_bad;
    logic [15:0]       w_cnt;

    assign w_accept = i_rx_valid && r_rx_ready;
    assign w_cnt    = {r_cnt[15:8], i_rx_data};
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0] r_chk;
    assign w_chk_bad = r_state == CHK && i_rx_data != r_chk;
    assign w_finish  = w_accept && r_state == CHK;
`else
    assign w_chk_bad = 1'b0;
    assign w_finish  = r_state == WRITE && r_cnt == 16'd1;
`endif
    // the watchdog outranks any byte arriving in the same cycle
    assign w_abort = w_expire || (w_accept && ((r_state == CNT_LO && (w_cnt == 16'd0 || w_cnt > MAX_WORDS))
                     || (r_state == B0 && |i_rx_data[7:2]) || w_chk_bad));

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (r_state == IDLE || w_accept),
        .i_en     (r_state != IDLE),
        .o_expire (w_expire)
    );

    // frame sequencer; every output is a register so WE/WDATA line up in the WRITE cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_word     <= '0;
            r_rx_ready <= 1'b0;
            r_we       <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
            r_chk      <= '0;
`endif
        end else begin
            r_rx_ready <= 1'b1;
            r_we       <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
                r_err   <= 1'b1;
                r_hold  <= 1'b0;
            end else if (w_finish) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (w_accept && i_rx_data == SYNC_BYTE) begin
                        r_state <= CNT_HI;
                        r_hold  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_addr  <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
                        r_chk   <= '0;
`endif
                    end
                    CNT_HI: if (w_accept) begin
                        r_cnt[15:8] <= i_rx_data;
                        r_state     <= CNT_LO;
                    end
                    CNT_LO: if (w_accept) begin
                        r_cnt   <= w_cnt;
                        r_state <= B0;
                    end
                    B0, B1, B2: if (w_accept) begin
                        if (r_state == B0) r_word[DATA_W-1:16] <= i_rx_data[1:0];
                        if (r_state == B1) r_word[15:8] <= i_rx_data;
                        if (r_state == B2) r_word[7:0] <= i_rx_data;
`ifdef PROG_LOADER_CHKSUM_EN
                        r_chk <= r_chk ^ i_rx_data;
`endif
                        r_state    <= r_state == B0 ? B1 : r_state == B1 ? B2 : WRITE;
                        r_we       <= r_state == B2;
                        r_rx_ready <= r_state != B2;
                    end
                    WRITE: begin
                        r_addr  <= r_addr + 1'b1;
                        r_cnt   <= r_cnt - 1'b1;
`ifdef PROG_LOADER_CHKSUM_EN
                        r_state <= r_cnt == 16'd1 ? CHK : B0;
`else
                        r_state <= B0;
`endif
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_rx_ready = r_rx_ready;
    assign o_we       = r_we;
    assign o_waddr    = r_addr;
    assign o_wdata    = r_word;
    assign o_hold     = r_hold;
    assign o_done     = r_done;
    assign o_err      = r_err;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of framing, write strobes, status, timeout and async reset
module tb_prog_loader;
    typedef logic [7:0] bq_t[$];
    logic        clk = 1'b0, rst = 1'b0, rx_valid = 1'b0, rx_ready, we, hold, done, err;
    logic [7:0]  rx_data = '0;
    logic [9:0]  waddr;
    logic [17:0] wdata;
    int          checks = 0, failures = 0;
    int          nw = 0, we_run = 0, we_max = 0, we_bad_ready = 0;
    logic [9:0]  wr_addr [0:15];
    logic [17:0] wr_data [0:15];

    prog_loader #(.TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready), .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
        .o_hold(hold), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    // write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (we) begin
            if (nw < 16) begin
                wr_addr[nw] = waddr;
                wr_data[nw] = wdata;
            end
            nw++;
            we_run++;
            if (we_run > we_max) we_max = we_run;
            if (rx_ready) we_bad_ready++;
        end else we_run = 0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!rx_ready) begin
            failures++;
            $display("FAIL send_ready got=%b exp=1", rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input bq_t q);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic wait_status();
        int n = 0;
        while (!(done || err) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(done || err)) begin
            failures++;
            $display("FAIL status_wait got done=%b err=%b exp=one set", done, err);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_ready, we, waddr, wdata, hold, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {rx_ready, we, waddr, wdata, hold, done, err});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_rise got=%b exp=1", rx_ready);
        end
    endtask

    task automatic test_bad_count();
        bq_t cnts = '{8'h00, 8'h00, 8'h04, 8'h01};
        for (int k = 0; k < 2; k++) begin
            nw = 0;
            send_seq('{8'hA5, cnts[2*k], cnts[2*k+1]});
            checks++;
            if ({err, done, hold} !== 3'b100) begin
                failures++;
                $display("FAIL bad_count%0d err_done_hold got=%b exp=100", k, {err, done, hold});
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (nw !== 0) begin
                failures++;
                $display("FAIL bad_count%0d writes got=%0d exp=0", k, nw);
            end
        end
    endtask

    task automatic test_load();
        nw = 0;
        we_max = 0;
        we_bad_ready = 0;
        send(8'h A5);
        checks++;
        if ({hold, done, err} !== 3'b100) begin
            failures++;
            $display("FAIL load_sync hold_done_err got=%b exp=100", {hold, done, err});
        end
        send_seq('{8'h00, 8'h02, 8'h03, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD});
`ifdef PROG_LOADER_CHKSUM_EN
        send(8'h43);
`endif
        wait_status();
        checks++;
        if (nw !== 2) begin
            failures++;
            $display("FAIL load_count got=%0d exp=2", nw);
        end
        checks++;
        if ({wr_addr[0], wr_data[0]} !== {10'd0, 18'h31234}) begin
            failures++;
            $display("FAIL load_word0 got=%h:%h exp=000:31234", wr_addr[0], wr_data[0]);
        end
        checks++;
        if ({wr_addr[1], wr_data[1]} !== {10'd1, 18'h0ABCD}) begin
            failures++;
            $display("FAIL load_word1 got=%h:%h exp=001:0abcd", wr_addr[1], wr_data[1]);
        end
        checks++;
        if ({done, err, hold} !== 3'b100) begin
            failures++;
            $display("FAIL load_status done_err_hold got=%b exp=100", {done, err, hold});
        end
        checks++;
        if (we_max !== 1 || we_bad_ready !== 0) begin
            failures++;
            $display("FAIL load_we_pulse got=width%0d/ready%0d exp=width1/ready0", we_max, we_bad_ready);
        end
    endtask

`ifdef PROG_LOADER_CHKSUM_EN
    task automatic test_chk_bad();
        nw = 0;
        send_seq('{8'hA5, 8'h00, 8'h02, 8'h03, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD, 8'h40});
        checks++;
        if (nw !== 2 || {err, done, hold} !== 3'b100) begin
            failures++;
            $display("FAIL chk_bad got=writes%0d/%b exp=writes2/100", nw, {err, done, hold});
        end
    endtask
`endif

    task automatic test_b0_bad();
        nw = 0;
        send_seq('{8'hA5, 8'h00, 8'h02, 8'h03, 8'h12, 8'h34, 8'h04});
        checks++;
        if ({err, done, hold} !== 3'b100) begin
            failures++;
            $display("FAIL b0_bad status got=%b exp=100", {err, done, hold});
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (nw !== 1 || wr_data[0] !== 18'h31234) begin
            failures++;
            $display("FAIL b0_bad writes got=%0d/%h exp=1/31234", nw, wr_data[0]);
        end
    endtask

    task automatic test_timeout();
        send_seq('{8'hA5, 8'h00, 8'h01, 8'h03});
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if ({err, hold} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_early err_hold got=%b exp=01", {err, hold});
        end
        @(posedge clk); #1;
        checks++;
        if ({err, done, hold, rx_ready} !== 4'b1001) begin
            failures++;
            $display("FAIL timeout_abort err_done_hold_ready got=%b exp=1001", {err, done, hold, rx_ready});
        end
        repeat (2) @(posedge clk);
        send(8'h12);
        checks++;
        if (hold !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle hold got=%b exp=0", hold);
        end
    endtask

    task automatic test_rst_mid();
        send_seq('{8'hA5, 8'h00, 8'h01, 8'h03, 8'h12});
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_ready, we, waddr, wdata, hold, done, err} !== '0) begin
            failures++;
            $display("FAIL rst_mid_async got=%h exp=0", {rx_ready, we, waddr, wdata, hold, done, err});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nw = 0;
        send_seq('{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h45});
`ifdef PROG_LOADER_CHKSUM_EN
        send(8'h67);
`endif
        wait_status();
        checks++;
        if (nw !== 1 || {wr_addr[0], wr_data[0]} !== {10'd0, 18'h12345} || {done, err} !== 2'b10) begin
            failures++;
            $display("FAIL rst_mid_reload got=%0d/%h:%h/%b exp=1/000:12345/10", nw, wr_addr[0], wr_data[0], {done, err});
        end
    endtask

    initial begin
        test_reset();
        test_bad_count();
        test_load();
`ifdef PROG_LOADER_CHKSUM_EN
        test_chk_bad();
`endif
        test_b0_bad();
        test_timeout();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
